// File: rtl/cp0_vic.sv
// cp0_vic: CP0 register file (STATUS, CAUSE, EPC, EHB) with a fixed-priority
// vectored interrupt controller. Reads in ID, writes in EXE, and a forced
// pipeline jump on interrupt entry or ERET.
module cp0_vic #(
   parameter int unsigned N_IRQ      = 8,
   parameter int unsigned VECTORED   = 0,
   parameter int unsigned VEC_SHIFT  = 5,
   parameter logic [4:0]  ADDR_STAT  = 5'd12,
   parameter logic [4:0]  ADDR_CAUSE = 5'd13,
   parameter logic [4:0]  ADDR_EPC   = 5'd14,
   parameter logic [4:0]  ADDR_EHB   = 5'd15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       oper,
   input  logic [4:0]       addr_r,
   output logic [31:0]      data_r,
   input  logic [4:0]       addr_w,
   input  logic [31:0]      data_w,
   input  logic             ir_en,
   input  logic [N_IRQ-1:0] irq_in,
   input  logic [31:0]      ret_addr,
   output logic             jump_en,
   output logic [31:0]      jump_addr
);

   logic             r_ie;
   logic             r_exl;
   logic [N_IRQ-1:0] r_mask;
   logic [N_IRQ-1:0] r_pend;
   logic [3:0]       r_code;
   logic [31:0]      r_epc;
   logic [31:2]      r_ehb;
   logic [31:0]      r_data_r;
   logic [N_IRQ-1:0] r_irq_prev;

   logic             w_store;
   logic             w_eret;
   logic             w_take;
   logic             w_wr_stat;
   logic             w_wr_cause;
   logic             w_wr_epc;
   logic             w_wr_ehb;
   logic [N_IRQ-1:0] w_rise;
   logic [N_IRQ-1:0] w_active;
   logic [N_IRQ-1:0] w_sel_1h;
   logic [N_IRQ-1:0] w_clr;
   logic             w_found;
   logic [3:0]       w_idx;
   logic [31:0]      w_ehb;
   logic [31:0]      w_vec_off;
   logic [31:0]      w_status;
   logic [31:0]      w_status_new;
   logic [31:0]      w_cause;
   logic [31:0]      w_cause_new;
   logic [31:0]      w_rd;

   assign w_store  = (oper == 2'b01);
   assign w_eret   = (oper == 2'b10);
   assign w_rise   = irq_in & ~r_irq_prev;
   assign w_active = r_pend & r_mask;
   assign w_ehb    = {r_ehb, 2'b00};

   // ERET takes precedence; a blocked interrupt is simply re-evaluated next cycle
   assign w_take = ir_en & r_ie & ~r_exl & (|w_active) & ~w_eret;

   // STATUS/CAUSE/EPC stores are dropped when an interrupt is taken; EHB is not
   assign w_wr_stat  = w_store & (addr_w == ADDR_STAT)  & ~w_take;
   assign w_wr_cause = w_store & (addr_w == ADDR_CAUSE) & ~w_take;
   assign w_wr_epc   = w_store & (addr_w == ADDR_EPC)   & ~w_take;
   assign w_wr_ehb   = w_store & (addr_w == ADDR_EHB);

   // Lowest-index pending and unmasked source wins
   always_comb begin
      w_idx    = '0;
      w_sel_1h = '0;
      w_found  = 1'b0;
      for (int unsigned i = 0; i < N_IRQ; i++) begin
         if (w_active[i] && !w_found) begin
            w_idx       = 4'(i);
            w_sel_1h[i] = 1'b1;
            w_found     = 1'b1;
         end
      end
   end

   assign w_vec_off = 32'(w_idx) << VEC_SHIFT;

   // PEND bits cleared this edge by take-ack or W1C store; rises override later
   assign w_clr = (w_take ? w_sel_1h : '0) | (w_wr_cause ? data_w[N_IRQ-1:0] : '0);

   // Register views: current contents and the value a same-cycle store would produce
   always_comb begin
      w_status              = '0;
      w_status[0]           = r_ie;
      w_status[1]           = r_exl;
      w_status[8 +: N_IRQ]  = r_mask;
      w_status_new             = '0;
      w_status_new[1:0]        = data_w[1:0];
      w_status_new[8 +: N_IRQ] = data_w[8 +: N_IRQ];
      w_cause               = '0;
      w_cause[N_IRQ-1:0]    = r_pend;
      w_cause[19:16]        = r_code;
      w_cause_new            = w_cause;
      w_cause_new[N_IRQ-1:0] = r_pend & ~data_w[N_IRQ-1:0];
   end

   // Read mux with write-to-read bypass of the effective store
   always_comb begin
      w_rd = '0;
      if (addr_r == ADDR_STAT)
         w_rd = (w_wr_stat && addr_w == addr_r) ? w_status_new : w_status;
      else if (addr_r == ADDR_CAUSE)
         w_rd = (w_wr_cause && addr_w == addr_r) ? w_cause_new : w_cause;
      else if (addr_r == ADDR_EPC)
         w_rd = (w_wr_epc && addr_w == addr_r) ? data_w : r_epc;
      else if (addr_r == ADDR_EHB)
         w_rd = (w_wr_ehb && addr_w == addr_r) ? {data_w[31:2], 2'b00} : w_ehb;
   end

   // Forced jump strobe and target, held quiet during reset
   always_comb begin
      jump_en   = 1'b0;
      jump_addr = '0;
      if (rst) begin
         if (w_eret) begin
            jump_en   = 1'b1;
            jump_addr = r_epc;
         end else if (w_take) begin
            jump_en   = 1'b1;
            jump_addr = w_ehb + ((VECTORED != 0) ? w_vec_off : '0);
         end
      end
   end

   // CP0 register state, edge detector and registered read data
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_ie       <= 1'b0;
         r_exl      <= 1'b0;
         r_mask     <= '0;
         r_pend     <= '0;
         r_code     <= '0;
         r_epc      <= '0;
         r_ehb      <= '0;
         r_data_r   <= '0;
         r_irq_prev <= '0;
      end else begin
         r_irq_prev <= irq_in;
         r_pend     <= (r_pend & ~w_clr) | w_rise;
         r_data_r   <= w_rd;
         if (w_take) begin
            r_exl  <= 1'b1;
            r_epc  <= ret_addr;
            r_code <= w_idx;
         end else if (w_eret) begin
            r_exl <= 1'b0;
         end else if (w_wr_stat) begin
            r_ie   <= data_w[0];
            r_exl  <= data_w[1];
            r_mask <= data_w[8 +: N_IRQ];
         end
         if (w_wr_epc)
            r_epc <= data_w;
         if (w_wr_ehb)
            r_ehb <= data_w[31:2];
      end
   end

   assign data_r = r_data_r;

endmodule

// File: tb/tb_cp0_vic.sv
// tb_cp0_vic: directed, table-driven bench for cp0_vic. Two instances share
// all stimulus; one is non-vectored, the other vectored with 32-byte spacing.
module tb_cp0_vic;

   localparam logic [1:0] NO = 2'b00;
   localparam logic [1:0] ST = 2'b01;
   localparam logic [1:0] ER = 2'b10;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  oper;
   logic [4:0]  addr_r;
   logic [4:0]  addr_w;
   logic [31:0] data_w;
   logic        ir_en;
   logic [7:0]  irq_in;
   logic [31:0] ret_addr;
   logic [31:0] d0_data_r, d1_data_r;
   logic        d0_jump_en, d1_jump_en;
   logic [31:0] d0_jump_addr, d1_jump_addr;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   cp0_vic #(.N_IRQ(8), .VECTORED(0), .VEC_SHIFT(5)) dut0 (
      .clk(clk), .rst(rst), .oper(oper), .addr_r(addr_r), .data_r(d0_data_r),
      .addr_w(addr_w), .data_w(data_w), .ir_en(ir_en), .irq_in(irq_in),
      .ret_addr(ret_addr), .jump_en(d0_jump_en), .jump_addr(d0_jump_addr));

   cp0_vic #(.N_IRQ(8), .VECTORED(1), .VEC_SHIFT(5)) dut1 (
      .clk(clk), .rst(rst), .oper(oper), .addr_r(addr_r), .data_r(d1_data_r),
      .addr_w(addr_w), .data_w(data_w), .ir_en(ir_en), .irq_in(irq_in),
      .ret_addr(ret_addr), .jump_en(d1_jump_en), .jump_addr(d1_jump_addr));

   // One cycle of inputs plus the outputs expected during that cycle;
   // d is the read data visible this cycle (read issued the cycle before).
   typedef struct {
      logic [1:0]  op;
      logic [4:0]  ar;
      logic [4:0]  aw;
      logic [31:0] dw;
      logic [7:0]  irq;
      logic        ien;
      logic [31:0] ret;
      logic        je;
      logic [31:0] ja;
      logic [31:0] jav;
      logic        cd;
      logic [31:0] d;
   } vec_t;

   vec_t tbl[16];

   function automatic vec_t mk(logic [1:0] op, logic [4:0] ar, logic [4:0] aw,
                               logic [31:0] dw, logic [7:0] irq, logic ien,
                               logic [31:0] ret, logic je, logic [31:0] ja,
                               logic [31:0] jav, logic cd, logic [31:0] d);
      vec_t v;
      v.op = op; v.ar = ar; v.aw = aw; v.dw = dw; v.irq = irq; v.ien = ien;
      v.ret = ret; v.je = je; v.ja = ja; v.jav = jav; v.cd = cd; v.d = d;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, got, exp);
   endtask

   // Called just after a rising edge: drive, check mid-cycle, advance one edge
   task automatic run(input vec_t v, input string tag);
      oper = v.op; addr_r = v.ar; addr_w = v.aw; data_w = v.dw;
      irq_in = v.irq; ir_en = v.ien; ret_addr = v.ret;
      @(negedge clk);
      chk({tag, ".je0"}, {31'b0, d0_jump_en}, {31'b0, v.je});
      chk({tag, ".je1"}, {31'b0, d1_jump_en}, {31'b0, v.je});
      if (v.je) begin
         chk({tag, ".ja0"}, d0_jump_addr, v.ja);
         chk({tag, ".ja1"}, d1_jump_addr, v.jav);
      end
      if (v.cd) begin
         chk({tag, ".d0"}, d0_data_r, v.d);
         chk({tag, ".d1"}, d1_data_r, v.d);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset to read-back, basic entry on irq 2, ERET, unmapped access
      tbl[0]  = mk(NO, 5'd12, 5'd0,  32'h0,    8'h00, 1'b0, 32'h0,  1'b0, 32'h0,   32'h0,   1'b1, 32'h0);
      tbl[1]  = mk(NO, 5'd13, 5'd0,  32'h0,    8'h00, 1'b0, 32'h0,  1'b0, 32'h0,   32'h0,   1'b1, 32'h0);
      tbl[2]  = mk(NO, 5'd14, 5'd0,  32'h0,    8'h00, 1'b0, 32'h0,  1'b0, 32'h0,   32'h0,   1'b1, 32'h0);
      tbl[3]  = mk(NO, 5'd15, 5'd0,  32'h0,    8'h00, 1'b0, 32'h0,  1'b0, 32'h0,   32'h0,   1'b1, 32'h0);
      tbl[4]  = mk(ST, 5'd15, 5'd15, 32'h103,  8'h00, 1'b0, 32'h0,  1'b0, 32'h0,   32'h0,   1'b1, 32'h0);
      tbl[5]  = mk(ST, 5'd12, 5'd12, 32'h401,  8'h00, 1'b0, 32'h0,  1'b0, 32'h0,   32'h0,   1'b1, 32'h100);
      tbl[6]  = mk(NO, 5'd13, 5'd0,  32'h0,    8'h04, 1'b1, 32'h40, 1'b0, 32'h0,   32'h0,   1'b1, 32'h401);
      tbl[7]  = mk(NO, 5'd13, 5'd0,  32'h0,    8'h04, 1'b1, 32'h40, 1'b1, 32'h100, 32'h140, 1'b1, 32'h0);
      tbl[8]  = mk(NO, 5'd12, 5'd0,  32'h0,    8'h00, 1'b1, 32'h0,  1'b0, 32'h0,   32'h0,   1'b1, 32'h4);
      tbl[9]  = mk(NO, 5'd13, 5'd0,  32'h0,    8'h00, 1'b1, 32'h0,  1'b0, 32'h0,   32'h0,   1'b1, 32'h403);
      tbl[10] = mk(NO, 5'd14, 5'd0,  32'h0,    8'h00, 1'b1, 32'h0,  1'b0, 32'h0,   32'h0,   1'b1, 32'h20000);
      tbl[11] = mk(ER, 5'd12, 5'd0,  32'h0,    8'h00, 1'b1, 32'h0,  1'b1, 32'h40,  32'h40,  1'b1, 32'h40);
      tbl[12] = mk(NO, 5'd12, 5'd0,  32'h0,    8'h00, 1'b1, 32'h0,  1'b0, 32'h0,   32'h0,   1'b1, 32'h403);
      tbl[13] = mk(NO, 5'd0,  5'd0,  32'h0,    8'h00, 1'b1, 32'h0,  1'b0, 32'h0,   32'h0,   1'b1, 32'h401);
      tbl[14] = mk(ST, 5'd3,  5'd3,  32'hFFFF, 8'h00, 1'b1, 32'h0,  1'b0, 32'h0,   32'h0,   1'b1, 32'h0);
      tbl[15] = mk(NO, 5'd0,  5'd0,  32'h0,    8'h00, 1'b1, 32'h0,  1'b0, 32'h0,   32'h0,   1'b1, 32'h0);

      rst = 1'b0; oper = NO; addr_r = '0; addr_w = '0; data_w = '0;
      ir_en = 1'b1; irq_in = 8'h00; ret_addr = '0;

      // Reset held: no jump even with toggling interrupt lines
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         irq_in = (i == 0) ? 8'hFF : 8'h55;
         @(negedge clk);
         chk("rst.je0", {31'b0, d0_jump_en}, 32'h0);
         chk("rst.ja0", d0_jump_addr, 32'h0);
         chk("rst.je1", {31'b0, d1_jump_en}, 32'h0);
      end
      @(posedge clk);
      #1;
      rst = 1'b1; irq_in = 8'h00; ir_en = 1'b0;

      for (int i = 0; i < 16; i++) run(tbl[i], $sformatf("tbl%0d", i));

      // Priority: irq 3 and 5 together, take 3; ERET; then 5
      run(mk(ST, 5'd0,  5'd12, 32'h2801, 8'h00, 1'b1, 32'h0,  1'b0, 32'h0,   32'h0,   1'b0, 32'h0), "P1");
      run(mk(NO, 5'd0,  5'd0,  32'h0,    8'h28, 1'b1, 32'h80, 1'b0, 32'h0,   32'h0,   1'b0, 32'h0), "P2");
      run(mk(NO, 5'd0,  5'd0,  32'h0,    8'h28, 1'b1, 32'h80, 1'b1, 32'h100, 32'h160, 1'b0, 32'h0), "P3");
      run(mk(NO, 5'd13, 5'd0,  32'h0,    8'h00, 1'b1, 32'h0,  1'b0, 32'h0,   32'h0,   1'b0, 32'h0), "P4");
      run(mk(ER, 5'd0,  5'd0,  32'h0,    8'h00, 1'b1, 32'h55, 1'b1, 32'h80,  32'h80,  1'b1, 32'h30020), "P5");
      run(mk(NO, 5'd0,  5'd0,  32'h0,    8'h00, 1'b1, 32'h90, 1'b1, 32'h100, 32'h1A0, 1'b1, 32'h0), "P6");
      run(mk(NO, 5'd13, 5'd0,  32'h0,    8'h00, 1'b1, 32'h0,  1'b0, 32'h0,   32'h0,   1'b0, 32'h0), "P7");
      run(mk(NO, 5'd0,  5'd0,  32'h0,    8'h00, 1'b1, 32'h0,  1'b0, 32'h0,   32'h0,   1'b1, 32'h50000), "P8");

      // ERET vs take: irq 1 held pending by ir_en=0, ERET wins, take follows
      run(mk(ST, 5'd0,  5'd12, 32'h201,  8'h00, 1'b0, 32'h0,  1'b0, 32'h0,   32'h0,   1'b0, 32'h0), "E1");
      run(mk(NO, 5'd0,  5'd0,  32'h0,    8'h02, 1'b0, 32'h0,  1'b0, 32'h0,   32'h0,   1'b0, 32'h0), "E2");
      run(mk(NO, 5'd0,  5'd0,  32'h0,    8'h02, 1'b0, 32'h0,  1'b0, 32'h0,   32'h0,   1'b0, 32'h0), "E3");
      run(mk(NO, 5'd0,  5'd0,  32'h0,    8'h00, 1'b0, 32'h0,  1'b0, 32'h0,   32'h0,   1'b0, 32'h0), "E4");
      run(mk(ER, 5'd0,  5'd0,  32'h0,    8'h00, 1'b1, 32'hEE, 1'b1, 32'h90,  32'h90,  1'b0, 32'h0), "E5");
      run(mk(NO, 5'd0,  5'd0,  32'h0,    8'h00, 1'b1, 32'hA0, 1'b1, 32'h100, 32'h120, 1'b0, 32'h0), "E6");
      run(mk(NO, 5'd14, 5'd0,  32'h0,    8'h00, 1'b1, 32'h0,  1'b0, 32'h0,   32'h0,   1'b0, 32'h0), "E7");
      run(mk(NO, 5'd13, 5'd0,  32'h0,    8'h00, 1'b1, 32'h0,  1'b0, 32'h0,   32'h0,   1'b1, 32'hA0), "E8");
      run(mk(NO, 5'd0,  5'd0,  32'h0,    8'h00, 1'b1, 32'h0,  1'b0, 32'h0,   32'h0,   1'b1, 32'h10000), "E9");

      // Masked pending, W1C clear, then a rise coinciding with W1C
      run(mk(ER, 5'd0,  5'd0,  32'h0,    8'h00, 1'b1, 32'h0,  1'b1, 32'hA0,  32'hA0,  1'b0, 32'h0), "M1");
      run(mk(ST, 5'd0,  5'd12, 32'h1,    8'h00, 1'b1, 32'h0,  1'b0, 32'h0,   32'h0,   1'b0, 32'h0), "M2");
      run(mk(NO, 5'd0,  5'd0,  32'h0,    8'h02, 1'b1, 32'h0,  1'b0, 32'h0,   32'h0,   1'b0, 32'h0), "M3");
      run(mk(NO, 5'd13, 5'd0,  32'h0,    8'h00, 1'b1, 32'h0,  1'b0, 32'h0,   32'h0,   1'b0, 32'h0), "M4");
      run(mk(ST, 5'd13, 5'd13, 32'h2,    8'h00, 1'b1, 32'h0,  1'b0, 32'h0,   32'h0,   1'b1, 32'h10002), "M5");
      run(mk(NO, 5'd13, 5'd0,  32'h0,    8'h00, 1'b1, 32'h0,  1'b0, 32'h0,   32'h0,   1'b1, 32'h10000), "M6");
      run(mk(NO, 5'd0,  5'd0,  32'h0,    8'h02, 1'b1, 32'h0,  1'b0, 32'h0,   32'h0,   1'b1, 32'h10000), "M7");
      run(mk(NO, 5'd0,  5'd0,  32'h0,    8'h00, 1'b1, 32'h0,  1'b0, 32'h0,   32'h0,   1'b0, 32'h0), "M8");
      run(mk(ST, 5'd13, 5'd13, 32'h2,    8'h02, 1'b1, 32'h0,  1'b0, 32'h0,   32'h0,   1'b0, 32'h0), "M9");
      run(mk(NO, 5'd13, 5'd0,  32'h0,    8'h02, 1'b1, 32'h0,  1'b0, 32'h0,   32'h0,   1'b1, 32'h10000), "M10");
      run(mk(NO, 5'd0,  5'd0,  32'h0,    8'h00, 1'b1, 32'h0,  1'b0, 32'h0,   32'h0,   1'b1, 32'h10002), "M11");

      // Vectored target for irq 3; STORE EPC in the take cycle is dropped
      run(mk(ST, 5'd0,  5'd12, 32'h801,  8'h00, 1'b1, 32'h0,  1'b0, 32'h0,   32'h0,   1'b0, 32'h0), "V1");
      run(mk(NO, 5'd0,  5'd0,  32'h0,    8'h08, 1'b1, 32'h0,  1'b0, 32'h0,   32'h0,   1'b0, 32'h0), "V2");
      run(mk(ST, 5'd0,  5'd14, 32'hDEAD, 8'h08, 1'b1, 32'hC0, 1'b1, 32'h100, 32'h160, 1'b0, 32'h0), "V3");
      run(mk(NO, 5'd14, 5'd0,  32'h0,    8'h00, 1'b1, 32'h0,  1'b0, 32'h0,   32'h0,   1'b0, 32'h0), "V4");
      run(mk(NO, 5'd13, 5'd0,  32'h0,    8'h00, 1'b1, 32'h0,  1'b0, 32'h0,   32'h0,   1'b1, 32'hC0), "V5");
      run(mk(NO, 5'd0,  5'd0,  32'h0,    8'h00, 1'b1, 32'h0,  1'b0, 32'h0,   32'h0,   1'b1, 32'h30002), "V6");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
